// File: rtl/dht11_sensor_ctrl.sv
// rtl/dht11_sensor_ctrl.sv - DHT11 single-wire master: start pulse, response/bit timing, checksum
`timescale 1ns/1ps
module dht11_sensor_ctrl #(
    parameter int CLK_FREQ_HZ    = 100_000_000,
    parameter int START_LOW_US   = 18000,
    parameter int TIMEOUT_US     = 200,
    parameter int BIT_THRESH_US  = 50,
    parameter int AUTO_PERIOD_US = 2_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    inout  wire        dht_signal,
    output logic [7:0] hum_high,
    output logic [7:0] hum_low,
    output logic [7:0] tem_high,
    output logic [7:0] tem_low,
    output logic [7:0] checksum,
    output logic       valid,
    output logic       busy,
    output logic [1:0] err
);

    localparam logic [31:0] TICK_LAST   = 32'(CLK_FREQ_HZ / 1_000_000 - 1);
    localparam logic [31:0] START_LIM   = 32'(START_LOW_US);
    localparam logic [31:0] TIMEOUT_LIM = 32'(TIMEOUT_US);
    localparam logic [31:0] THRESH      = 32'(BIT_THRESH_US);
    localparam bit          AUTO_EN     = (AUTO_PERIOD_US != 0);
    localparam logic [31:0] AUTO_LAST   = AUTO_EN ? 32'(AUTO_PERIOD_US - 1) : 32'd0;

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_WAIT_RESP, S_RESP_LOW, S_RESP_HIGH,
        S_BIT_LOW, S_BIT_HIGH, S_CHECK, S_END
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] presc_q, presc_d;
    logic [31:0] us_cnt_q, us_cnt_d;
    logic [31:0] auto_cnt_q, auto_cnt_d;
    logic        sync1_q, sync2_q, prev_q;
    logic [5:0]  bit_idx_q, bit_idx_d;
    logic [39:0] shift_q, shift_d;
    logic [7:0]  hum_high_q, hum_high_d, hum_low_q, hum_low_d;
    logic [7:0]  tem_high_q, tem_high_d, tem_low_q, tem_low_d;
    logic [7:0]  checksum_q, checksum_d;
    logic        valid_q, valid_d;
    logic [1:0]  err_q, err_d;
    logic        drive_low;

    logic       tick, auto_fire, rise, fall, timeout, bit_val, chk_ok, phase_timed;
    logic [7:0] sum8;

    assign tick      = (presc_q == TICK_LAST);
    assign auto_fire = AUTO_EN && tick && (auto_cnt_q == AUTO_LAST);
    assign rise      = sync2_q & ~prev_q;
    assign fall      = ~sync2_q & prev_q;
    assign timeout   = (us_cnt_q == TIMEOUT_LIM);
    assign bit_val   = (us_cnt_q > THRESH);
    assign sum8      = shift_q[39:32] + shift_q[31:24] + shift_q[23:16] + shift_q[15:8];
    assign chk_ok    = (sum8 == shift_q[7:0]);
    // Sensor-driven phases are the only ones that abort with a timeout error.
    assign phase_timed = (state_q == S_WAIT_RESP) || (state_q == S_RESP_LOW) ||
                         (state_q == S_RESP_HIGH) || (state_q == S_BIT_LOW) ||
                         (state_q == S_BIT_HIGH);

    // Register all state; async reset returns to idle with the line released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            presc_q    <= '0;
            us_cnt_q   <= '0;
            auto_cnt_q <= '0;
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            prev_q     <= 1'b1;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            hum_high_q <= '0;
            hum_low_q  <= '0;
            tem_high_q <= '0;
            tem_low_q  <= '0;
            checksum_q <= '0;
            valid_q    <= 1'b0;
            err_q      <= 2'b00;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            us_cnt_q   <= us_cnt_d;
            auto_cnt_q <= auto_cnt_d;
            sync1_q    <= dht_signal;
            sync2_q    <= sync1_q;
            prev_q     <= sync2_q;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            hum_high_q <= hum_high_d;
            hum_low_q  <= hum_low_d;
            tem_high_q <= tem_high_d;
            tem_low_q  <= tem_low_d;
            checksum_q <= checksum_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
        end
    end

    // Protocol sequencing: edges advance the phase, timeouts abort to idle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (start || auto_fire) state_d = S_START;
            S_START:     if (us_cnt_q == START_LIM) state_d = S_WAIT_RESP;
            S_WAIT_RESP: if (fall) state_d = S_RESP_LOW;  else if (timeout) state_d = S_IDLE;
            S_RESP_LOW:  if (rise) state_d = S_RESP_HIGH; else if (timeout) state_d = S_IDLE;
            S_RESP_HIGH: if (fall) state_d = S_BIT_LOW;   else if (timeout) state_d = S_IDLE;
            S_BIT_LOW:   if (rise) state_d = S_BIT_HIGH;  else if (timeout) state_d = S_IDLE;
            S_BIT_HIGH: begin
                if (fall) state_d = (bit_idx_q == 6'd39) ? S_CHECK : S_BIT_LOW;
                else if (timeout) state_d = S_IDLE;
            end
            S_CHECK:     state_d = S_END;
            S_END:       if (rise || timeout) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Datapath: timing counters, bit capture, and frame commit on a good checksum.
    always_comb begin
        presc_d    = tick ? 32'd0 : presc_q + 32'd1;
        auto_cnt_d = auto_cnt_q;
        if (!AUTO_EN)
            auto_cnt_d = '0;
        else if (tick)
            auto_cnt_d = (auto_cnt_q == AUTO_LAST) ? 32'd0 : auto_cnt_q + 32'd1;
        if (state_d != state_q || state_q == S_IDLE)
            us_cnt_d = '0;
        else
            us_cnt_d = us_cnt_q + {31'd0, tick};
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        hum_high_d = hum_high_q;
        hum_low_d  = hum_low_q;
        tem_high_d = tem_high_q;
        tem_low_d  = tem_low_q;
        checksum_d = checksum_q;
        valid_d    = 1'b0;
        err_d      = err_q;
        if (state_q == S_RESP_HIGH && fall)
            bit_idx_d = '0;
        if (state_q == S_BIT_HIGH && fall) begin
            shift_d = {shift_q[38:0], bit_val};
            if (bit_idx_q != 6'd39) bit_idx_d = bit_idx_q + 6'd1;
        end
        if (phase_timed && state_d == S_IDLE)
            err_d = 2'b01;
        if (state_q == S_CHECK) begin
            if (chk_ok) begin
                hum_high_d = shift_q[39:32];
                hum_low_d  = shift_q[31:24];
                tem_high_d = shift_q[23:16];
                tem_low_d  = shift_q[15:8];
                checksum_d = shift_q[7:0];
                valid_d    = 1'b1;
                err_d      = 2'b00;
            end else begin
                err_d = 2'b10;
            end
        end
    end

    // Outputs decoded from state: pull the line low only during the start pulse.
    always_comb begin
        drive_low = (state_q == S_START);
        busy      = (state_q != S_IDLE);
    end

    assign dht_signal = drive_low ? 1'b0 : 1'bz;
    assign hum_high   = hum_high_q;
    assign hum_low    = hum_low_q;
    assign tem_high   = tem_high_q;
    assign tem_low    = tem_low_q;
    assign checksum   = checksum_q;
    assign valid      = valid_q;
    assign err        = err_q;

endmodule

// File: tb/tb_dht11_sensor_ctrl.sv
// tb/tb_dht11_sensor_ctrl.sv - scoreboard bench for dht11_sensor_ctrl with behavioural sensors
`timescale 1ns/1ps
module tb_dht11_sensor_ctrl;

    localparam int US = 20;  // 2 MHz design clock, 10 ns sim period -> 2 cycles per us

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b, start_a, start_b;
    wire  line_a, line_b;
    pullup (line_a);
    pullup (line_b);

    logic        sen_low   [2];
    logic [39:0] sen_frame [2];
    bit          sen_en    [2];
    int          bit_num   [2];
    int          lowlen    [2];

    assign line_a = sen_low[0] ? 1'b0 : 1'bz;
    assign line_b = sen_low[1] ? 1'b0 : 1'bz;

    logic [7:0] hum_high_a, hum_low_a, tem_high_a, tem_low_a, checksum_a;
    logic [7:0] hum_high_b, hum_low_b, tem_high_b, tem_low_b, checksum_b;
    logic       valid_a, busy_a, valid_b, busy_b;
    logic [1:0] err_a, err_b;

    dht11_sensor_ctrl #(.CLK_FREQ_HZ(2_000_000), .START_LOW_US(500), .TIMEOUT_US(200),
                        .BIT_THRESH_US(50), .AUTO_PERIOD_US(0)) dut_a (
        .clk(clk), .rst(rst_a), .start(start_a), .dht_signal(line_a),
        .hum_high(hum_high_a), .hum_low(hum_low_a), .tem_high(tem_high_a), .tem_low(tem_low_a),
        .checksum(checksum_a), .valid(valid_a), .busy(busy_a), .err(err_a));

    dht11_sensor_ctrl #(.CLK_FREQ_HZ(2_000_000), .START_LOW_US(500), .TIMEOUT_US(200),
                        .BIT_THRESH_US(50), .AUTO_PERIOD_US(5000)) dut_b (
        .clk(clk), .rst(rst_b), .start(start_b), .dht_signal(line_b),
        .hum_high(hum_high_b), .hum_low(hum_low_b), .tem_high(tem_high_b), .tem_low(tem_low_b),
        .checksum(checksum_b), .valid(valid_b), .busy(busy_b), .err(err_b));

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [39:0] frame;
        logic [1:0]  err;
        int          nvalid;
    } exp_t;
    exp_t exp_q[$];

    function automatic logic line_of(input int w);
        return (w == 0) ? line_a : line_b;
    endfunction

    // Sensor model: answers each host start pulse with response + 40 bits + end low.
    task automatic sensor_loop(input int w);
        forever begin
            int n;
            @(negedge clk);
            if (line_of(w) == 1'b0) begin
                n = 0;
                while (line_of(w) == 1'b0) begin
                    n++;
                    @(negedge clk);
                end
                lowlen[w]  = n;
                bit_num[w] = -1;
                if (sen_en[w]) begin
                    #(30*US); sen_low[w] = 1'b1;
                    #(80*US); sen_low[w] = 1'b0;
                    #(80*US);
                    for (int i = 0; i < 40; i++) begin
                        bit_num[w] = i;
                        sen_low[w] = 1'b1;
                        #(50*US);
                        sen_low[w] = 1'b0;
                        if (sen_frame[w][39-i]) #(70*US);
                        else #(26*US);
                    end
                    bit_num[w] = 40;
                    sen_low[w] = 1'b1;
                    #(50*US);
                    sen_low[w] = 1'b0;
                end
            end
        end
    endtask

    // Scoreboard for DUT A: every completed transaction pops one expectation.
    initial begin
        logic busy_prev;
        int   vcnt;
        exp_t e;
        busy_prev = 1'b0;
        vcnt = 0;
        forever begin
            @(negedge clk);
            if (busy_a && !busy_prev) vcnt = 0;
            if (valid_a) vcnt++;
            if (!busy_a && busy_prev) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_txn", 64'(1), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("sb_err",      64'(err_a),      64'(e.err));
                    check("sb_hum_high", 64'(hum_high_a), 64'(e.frame[39:32]));
                    check("sb_hum_low",  64'(hum_low_a),  64'(e.frame[31:24]));
                    check("sb_tem_high", 64'(tem_high_a), 64'(e.frame[23:16]));
                    check("sb_tem_low",  64'(tem_low_a),  64'(e.frame[15:8]));
                    check("sb_checksum", 64'(checksum_a), 64'(e.frame[7:0]));
                    check("sb_valid_pulses", 64'(vcnt),   64'(e.nvalid));
                end
            end
            busy_prev = busy_a;
        end
    end

    // Monitor for the auto-triggered DUT B: fixed interval, one good frame each time.
    int falls_b = 0;
    initial begin
        logic    busy_prev;
        int      vcnt;
        int      rises;
        longint  cyc;
        longint  last_rise;
        busy_prev = 1'b0;
        vcnt = 0;
        rises = 0;
        cyc = 0;
        last_rise = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (busy_b && !busy_prev) begin
                if (rises > 0) check("auto_interval_cycles", 64'(cyc - last_rise), 64'(10000));
                last_rise = cyc;
                rises++;
                vcnt = 0;
            end
            if (valid_b) vcnt++;
            if (!busy_b && busy_prev) begin
                check("auto_err",         64'(err_b),      64'(0));
                check("auto_hum_high",    64'(hum_high_b), 64'(8'h12));
                check("auto_tem_low",     64'(tem_low_b),  64'(8'h78));
                check("auto_checksum",    64'(checksum_b), 64'(8'h14));
                check("auto_valid_pulses", 64'(vcnt),      64'(1));
                falls_b++;
            end
            busy_prev = busy_b;
        end
    end

    initial begin
        #(10 * 150000);
        $display("FAIL watchdog: simulation time limit reached, required completion before it");
        $fatal(1);
    end

    task automatic pulse_start();
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!busy_a && n < 10) begin @(negedge clk); n++; end
        check({tag, "_busy_rise"}, 64'(busy_a), 64'(1));
        n = 0;
        while (busy_a && n < 15000) begin @(negedge clk); n++; end
        check({tag, "_busy_fall"}, 64'(busy_a), 64'(0));
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_bit(input int b, input string tag);
        int n;
        n = 0;
        while (bit_num[0] != b && n < 20000) begin @(negedge clk); n++; end
        check({tag, "_reach_bit"}, 64'(bit_num[0]), 64'(b));
    endtask

    initial begin
        int n;
        sen_low[0] = 1'b0; sen_low[1] = 1'b0;
        sen_en[0] = 1'b1;  sen_en[1] = 1'b1;
        sen_frame[0] = 40'h0;
        sen_frame[1] = 40'h12_34_56_78_14;
        bit_num[0] = -1; bit_num[1] = -1;
        lowlen[0] = 0;   lowlen[1] = 0;
        rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
        fork
            sensor_loop(0);
            sensor_loop(1);
        join_none
        repeat (5) @(negedge clk);
        check("rst_hum_high", 64'(hum_high_a), 64'(0));
        check("rst_checksum", 64'(checksum_a), 64'(0));
        check("rst_valid",    64'(valid_a),    64'(0));
        check("rst_busy",     64'(busy_a),     64'(0));
        check("rst_err",      64'(err_a),      64'(0));
        check("rst_line",     64'(line_a),     64'(1));
        rst_a = 1'b0; rst_b = 1'b0;
        repeat (5) @(negedge clk);

        // 1: good frame, start pulse length
        sen_frame[0] = 40'h37_00_19_05_55;
        exp_q.push_back('{40'h37_00_19_05_55, 2'b00, 1});
        pulse_start();
        wait_done("s1");
        check("s1_start_low_in_window", 64'(lowlen[0] >= 996 && lowlen[0] <= 1004), 64'(1));
        if (lowlen[0] < 996 || lowlen[0] > 1004)
            $display("info: start low lasted %0d cycles, window 996..1004", lowlen[0]);

        // 2: checksum mismatch keeps previous outputs
        sen_frame[0] = 40'h37_00_19_05_56;
        exp_q.push_back('{40'h37_00_19_05_55, 2'b10, 0});
        pulse_start();
        wait_done("s2");

        // 3: no sensor -> timeout 200 us after release
        sen_en[0] = 1'b0;
        exp_q.push_back('{40'h37_00_19_05_55, 2'b01, 0});
        pulse_start();
        n = 0;
        while (line_a !== 1'b0 && n < 20) begin @(negedge clk); n++; end
        n = 0;
        while (line_a !== 1'b1 && n < 1100) begin @(negedge clk); n++; end
        n = 0;
        while (busy_a && n < 2000) begin @(negedge clk); n++; end
        check("s3_timeout_in_window", 64'(n >= 397 && n <= 404), 64'(1));
        check("s3_err", 64'(err_a), 64'(1));
        repeat (3) @(negedge clk);
        sen_en[0] = 1'b1;

        // 4: start during BIT_LOW is ignored
        sen_frame[0] = 40'h41_00_1a_00_5b;
        exp_q.push_back('{40'h41_00_1a_00_5b, 2'b00, 1});
        pulse_start();
        wait_bit(10, "s4");
        #(10*US);
        pulse_start();
        n = 0;
        while (busy_a && n < 15000) begin @(negedge clk); n++; end
        check("s4_busy_fall", 64'(busy_a), 64'(0));
        repeat (100) @(negedge clk);
        check("s4_no_requeue", 64'(busy_a), 64'(0));

        // 5: reset mid-frame, then a fresh good frame
        sen_frame[0] = 40'h37_00_19_05_55;
        pulse_start();
        wait_bit(20, "s5");
        #(60*US);
        exp_q.push_back('{40'h0, 2'b00, 0});
        rst_a = 1'b1;
        #1;
        check("s5_busy_async",    64'(busy_a),     64'(0));
        check("s5_line_released", 64'(line_a),     64'(1));
        check("s5_hum_high_rst",  64'(hum_high_a), 64'(0));
        repeat (4) @(negedge clk);
        rst_a = 1'b0;
        wait_bit(40, "s5_tail");
        #(100*US);
        exp_q.push_back('{40'h37_00_19_05_55, 2'b00, 1});
        pulse_start();
        wait_done("s5b");

        // 6: auto-trigger DUT runs in parallel; wait for three transactions
        n = 0;
        while (falls_b < 3 && n < 60000) begin @(negedge clk); n++; end
        check("auto_txn_count", 64'(falls_b >= 3), 64'(1));
        check("sb_drained", 64'(exp_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
